bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader_pkg.sv | 4 +
 rtl/bram_stream_reader_fifo.sv | 34 +++
 rtl/bram_stream_reader.sv | 78 +++++++
 tb/tb_bram_stream_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared state encoding for the BRAM stream reader
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/bram_stream_reader_fifo.sv
// stream_fifo2: 2-entry fall-through FIFO, writes are credit-managed by the producer
module stream_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic rp, wp, pop, wr, rd;
  assign out_valid = count != 2'd0 || in_valid;
  assign out_data = count != 2'd0 ? mem[rp] : in_data;
  assign pop = out_valid && out_ready;
  assign rd = pop && count != 2'd0;
  assign wr = in_valid && !(pop && count == 2'd0);
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      rp <= 1'b0;
      wp <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= in_data;
        wp <= ~wp;
      end
      if (rd) rp <= ~rp;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams len words from a 1-cycle-latency BRAM read port starting at base_addr
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16384,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);
  state_t state, nxt;
  logic [AW-1:0] addr;
  logic [AW:0] len_r, left, sent;
  logic inflight, pop;
  logic [1:0] count;
  assign pop = m_valid && m_ready;
  assign mem_addr = addr;
  assign mem_en = state == RUN && ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign m_last = m_valid && sent == len_r - 1'b1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? (len != '0 ? RUN : DONE) : IDLE;
      RUN: nxt = mem_en && left == {{AW{1'b0}}, 1'b1} ? DRAIN : RUN;
      DRAIN: nxt = pop && m_last ? DONE : DRAIN;
      DONE: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      inflight <= 1'b0;
      addr <= '0;
      len_r <= '0;
      left <= '0;
      sent <= '0;
    end else begin
      state <= nxt;
      inflight <= mem_en;
      if (state == IDLE && start) begin
        addr <= base_addr;
        len_r <= len;
        left <= len;
        sent <= '0;
      end else begin
        if (mem_en) begin
          addr <= addr == AW'(DEPTH - 1) ? '0 : addr + 1'b1;
          left <= left - 1'b1;
        end
        if (pop) sent <= sent + 1'b1;
      end
    end
  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .in_valid(inflight),
    .in_data(mem_rdata),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data(m_data),
    .count(count)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: randomized and directed checks against a queue-based transfer model
module tb_bram_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16384;
  localparam int AW = 14;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] len = '0;
  logic busy, done, mem_en, m_valid, m_last;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata = '0, m_data;
  int tests = 0, fails = 0, rdy_mode = 0;
  bit chk_en = 0;
  logic [WIDTH-1:0] exp_w[$];
  logic [AW-1:0] exp_a[$];
  bit exp_busy = 0, exp_done = 0, pv = 0, pr = 0, pl = 0;
  logic [WIDTH-1:0] pd = '0;
  always #5 clk = ~clk;
  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );
  always @(posedge clk) if (mem_en) mem_rdata <= WIDTH'(mem_addr);
  task automatic chk(string n, logic [63:0] g, logic [63:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, g, e, $time);
    end
  endtask
  always @(negedge clk) begin
    bit acc, lastpop, nd;
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (done) chk("done_words_left", exp_w.size(), 0);
      if (mem_en) begin
        if (exp_a.size() == 0) chk("mem_en_spurious", 1, 0);
        else chk("mem_addr", mem_addr, exp_a.pop_front());
      end
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      lastpop = 0;
      if (m_valid) begin
        if (exp_w.size() == 0) chk("m_valid_spurious", 1, 0);
        else begin
          chk("m_data", m_data, exp_w[0]);
          chk("m_last", m_last, exp_w.size() == 1);
          lastpop = m_ready && exp_w.size() == 1;
          if (m_ready) void'(exp_w.pop_front());
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      acc = start && !exp_busy && !rst;
      if (acc)
        for (int i = 0; i < int'(len); i++) begin
          exp_a.push_back(AW'((int'(base_addr) + i) % DEPTH));
          exp_w.push_back(WIDTH'((int'(base_addr) + i) % DEPTH));
        end
      if (rst) begin
        exp_w.delete(); exp_a.delete();
        exp_busy = 0; exp_done = 0; pv = 0;
      end else begin
        nd = lastpop || (acc && len == '0);
        exp_busy = acc || (exp_busy && !exp_done);
        exp_done = nd;
      end
    end
  end
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
      k++;
    end
  end
  task automatic start_xfer(logic [AW-1:0] b, logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_timeout", seen, 1);
  endtask
  initial begin
    bit hit;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk_en = 1;
    rdy_mode = 0;
    start_xfer(14'h10, 15'd4);
    @(negedge clk);
    chk("c1_mem_en", mem_en, 1);
    chk("c1_mem_addr", mem_addr, 14'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_valid", m_valid, 1);
      chk("seq_data", m_data, 32'h10 + i);
      chk("seq_last", m_last, i == 3);
    end
    @(negedge clk);
    chk("seq_done", done, 1);
    start_xfer(14'h3FFE, 15'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_addr", mem_addr, i == 0 ? 14'h3FFE : i == 1 ? 14'h3FFF : i == 2 ? 14'h0000 : 14'h0001);
    end
    wait_done();
    start_xfer(14'h5, 15'd0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_mem_en", mem_en, 0);
    chk("len0_m_valid", m_valid, 0);
    rdy_mode = 1;
    start_xfer(14'h100, 15'd8);
    wait_done();
    rdy_mode = 0;
    start_xfer(14'h300, 15'd16);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = m_valid && m_ready && m_data == 32'h305;
    end
    chk("word5_seen", hit, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_m_last", m_last, 0);
    repeat (3) @(posedge clk);
    start_xfer(14'h0, 15'd2);
    wait_done();
    start_xfer(14'h200, 15'd3);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 14'h400; len = 15'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] b;
      logic [AW:0] l;
      rdy_mode = $urandom_range(0, 2);
      b = $urandom_range(0, 3) == 0 ? AW'(DEPTH - $urandom_range(1, 8)) : AW'($urandom);
      l = AW'($urandom_range(0, 12));
      start_xfer(b, l);
      if (l != '0 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'($urandom); len = (AW + 1)'($urandom_range(1, 5));
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("end_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
